regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised multi-register file for the CPU datapath, successor to the fixed 4-entry, 2-read/1-write register block. Adds the following:
- Generic width and depth.
- Byte write strobes.
- Optional hardwired zero register.
- Write-to-read bypass.
- Per-register pending (scoreboard) bits, so the issue stage can detect read-after-write hazards against in-flight writebacks.

Parameters:
N, 32, data width in bits; must be a multiple of 8
ADDR_W, 2, address width; DEPTH = 2**ADDR_W registers
ZERO_REG, 0, 1 = register 0 reads 0, ignores writes, never goes pending
BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  asynchronous, active-high reset
ra1  input  ADDR_W  read address, port 1
ra2  input  ADDR_W  read address, port 2
rd1  output  N  read data, port 1
rd2  output  N  read data, port 2
rbusy1  output  1  register at ra1 has a pending write
rbusy2  output  1  register at ra2 has a pending write
we  input  1  write enable (writeback)
wa  input  ADDR_W  write address
wd  input  N  write data
wstrb  input  N/8  byte strobes; bit i enables wd[8i+7:8i]
iss_valid  input  1  issue: mark register iss_addr pending
iss_addr  input  ADDR_W  destination register of the issued instruction
pend_cnt  output  ADDR_W+1  number of currently pending registers (registered)

Behaviour:
- Reset (async, while rst=1):
  - All DEPTH registers = 0.
  - All pending bits = 0; pend_cnt = 0.
  - Consequently rd1 = rd2 = 0 and rbusy1 = rbusy2 = 0.
  - Takes effect immediately, mid-cycle included. No write or issue is accepted while rst=1.
- Reads are combinational, 0-cycle latency:
  - rdX = mem[raX].
  - If BYPASS=1 and we=1 and wa==raX (and not the zero register), rdX = per-byte merge: wd byte where wstrb=1, else mem[raX] byte.
- Write at posedge when we=1:
  - mem[wa] byte i <= wd byte i only for wstrb[i]=1; other bytes unchanged.
  - we=1 with wstrb=0 changes no data but still clears pending[wa].
- Zero register (ZERO_REG=1, address 0):
  - rd = 0 regardless of bypass.
  - Writes are ignored.
  - iss_valid to address 0 is ignored; rbusy for address 0 is always 0.
- Scoreboard, updated at posedge:
  - iss_valid=1 sets pending[iss_addr].
  - we=1 clears pending[wa].
  - Same address, same cycle, both active: pending ends SET (the new issue wins; the old writeback completes).
  - iss_valid on an already-pending register: stays set, no count change.
  - we on a non-pending register: writes data, count unchanged.
- rbusyX = pending[raX], except 0 when BYPASS=1 and we=1 and wa==raX and NOT (iss_valid and iss_addr==raX). The data is available this cycle via bypass.
- pend_cnt:
  - Registered popcount of the pending bits; equals the count after the edge.
  - Range 0..DEPTH, with no wrap: the ADDR_W+1 width holds DEPTH.
- rd1 and rd2 are fully independent; ra1==ra2 is legal and both ports return the same value.

Test Plan (N=32, ADDR_W=2):
1. Reset, then write 32'h1, 32'h3, 32'h7, 32'hffffffff to regs 0..3 with wstrb=4'hf; read ra1=2, ra2=3 -> rd1=32'h7, rd2=32'hffffffff.
2. Reg 1 = 32'h11223344; we=1, wa=1, wd=32'hAABBCCDD, wstrb=4'b0101; same cycle ra1=1 -> rd1=32'h11BB33DD (bypass); next cycle still 32'h11BB33DD.
3. iss_valid on regs 1, 2, 3 in consecutive cycles -> pend_cnt 1, 2, 3; ra1=2 -> rbusy1=1. Then we to reg 2 -> during that cycle rbusy1=0 with rd1=wd; afterwards pend_cnt=2.
4. Same cycle iss_valid=1, iss_addr=1 and we=1, wa=1 while reg 1 is pending -> pending[1] stays 1, pend_cnt unchanged, rbusy for reg 1 = 1, data updated.
5. ZERO_REG=1 instance: we=1, wa=0, wd=32'd100 and iss_valid to reg 0 -> rd for address 0 = 0, rbusy=0, pend_cnt unchanged.
6. Assert rst mid-cycle with regs and pending non-zero -> immediately rd1=rd2=0, rbusy=0, pend_cnt=0. A we pulse during rst is ignored; the first write after rst falls is stored normally.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised 2-read / 1-write register file with byte strobes,
// optional hardwired zero register, write-to-read bypass and a per-register
// pending scoreboard used by the issue stage for RAW hazard detection.
module regfile_sb #(
    parameter int N        = 32,
    parameter int ADDR_W   = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [N-1:0]      rd1,
    output logic [N-1:0]      rd2,
    output logic              rbusy1,
    output logic              rbusy2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [N-1:0]      wd,
    input  logic [N/8-1:0]    wstrb,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = N / 8;

    logic [N-1:0]      mem_r [DEPTH];
    logic [DEPTH-1:0]  pend_r;
    logic [ADDR_W:0]   pend_cnt_r;

    logic              wr_en_s;
    logic              iss_en_s;
    logic [DEPTH-1:0]  pend_clr_s;
    logic [DEPTH-1:0]  pend_set_s;
    logic [DEPTH-1:0]  pend_nxt_s;
    logic              hit1_s;
    logic              hit2_s;

    // True when the address names the hardwired zero register
    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == {ADDR_W{1'b0}});
    endfunction

    // Per-byte merge: take the new byte where the strobe is set
    function automatic logic [N-1:0] byte_merge(input logic [N-1:0]  old_v,
                                                input logic [N-1:0]  new_v,
                                                input logic [NB-1:0] strb);
        logic [N-1:0] v;
        v = old_v;
        for (int b = 0; b < NB; b++) begin
            v[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return v;
    endfunction

    // Number of set bits in a pending vector
    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] c;
        c = {(ADDR_W+1){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            c = c + {{ADDR_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Effective write/issue: blocked during reset and towards the zero register
    always_comb begin
        wr_en_s  = we & ~rst & ~is_zero(wa);
        iss_en_s = iss_valid & ~rst & ~is_zero(iss_addr);
    end

    // Next pending vector: writeback clears first, issue sets last (issue wins)
    always_comb begin
        pend_clr_s = {DEPTH{1'b0}};
        pend_set_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            pend_clr_s[i] = wr_en_s  & (wa == ADDR_W'(i));
            pend_set_s[i] = iss_en_s & (iss_addr == ADDR_W'(i));
        end
        pend_nxt_s = (pend_r & ~pend_clr_s) | pend_set_s;
    end

    // Register storage with per-byte write strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {N{1'b0}};
            end
        end else if (wr_en_s) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) begin
                    mem_r[wa][8*b +: 8] <= wd[8*b +: 8];
                end
            end
        end
    end

    // Scoreboard bits and their registered population count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r     <= {DEPTH{1'b0}};
            pend_cnt_r <= {(ADDR_W+1){1'b0}};
        end else begin
            pend_r     <= pend_nxt_s;
            pend_cnt_r <= popcount(pend_nxt_s);
        end
    end

    // Bypass hit detection for each read port
    always_comb begin
        hit1_s = (BYPASS != 0) && wr_en_s && (wa == ra1);
        hit2_s = (BYPASS != 0) && wr_en_s && (wa == ra2);
    end

    // Combinational read ports; a bypass hit also hides the pending bit
    // unless a new issue to the same register lands in this cycle
    always_comb begin
        if (is_zero(ra1)) begin
            rd1 = {N{1'b0}};
        end else if (hit1_s) begin
            rd1 = byte_merge(mem_r[ra1], wd, wstrb);
        end else begin
            rd1 = mem_r[ra1];
        end
        if (is_zero(ra2)) begin
            rd2 = {N{1'b0}};
        end else if (hit2_s) begin
            rd2 = byte_merge(mem_r[ra2], wd, wstrb);
        end else begin
            rd2 = mem_r[ra2];
        end
        rbusy1 = pend_r[ra1] & ~(hit1_s & ~(iss_en_s & (iss_addr == ra1)));
        rbusy2 = pend_r[ra2] & ~(hit2_s & ~(iss_en_s & (iss_addr == ra2)));
    end

    assign pend_cnt = pend_cnt_r;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scenarios plus randomized traffic against a
// behavioural array model of the register file and scoreboard.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [1:0]  ra1, ra2, wa, iss_addr;
    logic [31:0] rd1, rd2, wd;
    logic        rbusy1, rbusy2, we, iss_valid;
    logic [3:0]  wstrb;
    logic [2:0]  pend_cnt;

    logic [1:0]  z_ra1, z_ra2, z_wa, z_iss_addr;
    logic [31:0] z_rd1, z_rd2, z_wd;
    logic        z_rbusy1, z_rbusy2, z_we, z_iss_valid;
    logic [3:0]  z_wstrb;
    logic [2:0]  z_pend_cnt;

    int total = 0;
    int bad   = 0;

    // behavioural model of the main instance
    logic [31:0] m_mem  [4];
    bit          m_pend [4];

    regfile_sb #(.N(32), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .rbusy1(rbusy1), .rbusy2(rbusy2), .we(we), .wa(wa), .wd(wd),
        .wstrb(wstrb), .iss_valid(iss_valid), .iss_addr(iss_addr),
        .pend_cnt(pend_cnt)
    );

    regfile_sb #(.N(32), .ADDR_W(2), .ZERO_REG(1), .BYPASS(1)) dut_z (
        .clk(clk), .rst(rst), .ra1(z_ra1), .ra2(z_ra2), .rd1(z_rd1), .rd2(z_rd2),
        .rbusy1(z_rbusy1), .rbusy2(z_rbusy2), .we(z_we), .wa(z_wa), .wd(z_wd),
        .wstrb(z_wstrb), .iss_valid(z_iss_valid), .iss_addr(z_iss_addr),
        .pend_cnt(z_pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merged(input logic [31:0] old_v);
        logic [31:0] v = old_v;
        for (int b = 0; b < 4; b++)
            if (wstrb[b]) v[8*b +: 8] = wd[8*b +: 8];
        return v;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        if (we && wa == a) return merged(m_mem[a]);
        return m_mem[a];
    endfunction

    function automatic logic m_busy(input logic [1:0] a);
        return m_pend[a] && !(we && wa == a && !(iss_valid && iss_addr == a));
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 4; i++) c += m_pend[i];
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_mem[i]  = 32'h0;
            m_pend[i] = 1'b0;
        end
    endtask

    // apply the current inputs to the model, then cross the clock edge
    task automatic tick();
        if (!rst) begin
            if (we) begin
                m_mem[wa]  = merged(m_mem[wa]);
                m_pend[wa] = 1'b0;
            end
            if (iss_valid) m_pend[iss_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; iss_valid = 1'b0; wstrb = 4'h0; wd = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); ra1 = 2'd0; ra2 = 2'd1; wa = 2'd0; iss_addr = 2'd0;
        z_we = 1'b0; z_iss_valid = 1'b0; z_wa = 2'd0; z_wd = 32'h0; z_wstrb = 4'h0;
        z_ra1 = 2'd0; z_ra2 = 2'd0; z_iss_addr = 2'd0;
        model_reset();
        #1;
        total++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0 || rbusy1 !== 1'b0 || rbusy2 !== 1'b0 || pend_cnt !== 3'd0) begin
            bad++;
            $display("FAIL reset: rd1=%h rd2=%h rbusy=%b%b cnt=%0d required all zero", rd1, rd2, rbusy1, rbusy2, pend_cnt);
        end
        #11;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        logic [31:0] vals [4];
        vals[0] = 32'h1; vals[1] = 32'h3; vals[2] = 32'h7; vals[3] = 32'hffffffff;
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; wa = 2'(i); wd = vals[i]; wstrb = 4'hf;
            tick();
        end
        idle(); ra1 = 2'd2; ra2 = 2'd3;
        #1;
        total++;
        if (rd1 !== 32'h7 || rd2 !== 32'hffffffff) begin
            bad++;
            $display("FAIL write_read: rd1=%h rd2=%h required 00000007 ffffffff", rd1, rd2);
        end
    endtask

    task automatic test_strobe_bypass();
        we = 1'b1; wa = 2'd1; wd = 32'h11223344; wstrb = 4'hf;
        tick();
        wd = 32'hAABBCCDD; wstrb = 4'b0101; ra1 = 2'd1;
        #1;
        total++;
        if (rd1 !== 32'h11BB33DD) begin
            bad++;
            $display("FAIL strobe_bypass: rd1=%h required 11bb33dd", rd1);
        end
        tick();
        idle();
        #1;
        total++;
        if (rd1 !== 32'h11BB33DD) begin
            bad++;
            $display("FAIL strobe_stored: rd1=%h required 11bb33dd", rd1);
        end
    endtask

    task automatic test_scoreboard();
        for (int i = 1; i <= 3; i++) begin
            iss_valid = 1'b1; iss_addr = 2'(i);
            tick();
            total++;
            if (pend_cnt !== 3'(i)) begin
                bad++;
                $display("FAIL issue_count: pend_cnt=%0d required %0d", pend_cnt, i);
            end
        end
        idle(); ra1 = 2'd2;
        #1;
        total++;
        if (rbusy1 !== 1'b1) begin
            bad++;
            $display("FAIL busy_pending: rbusy1=%b required 1", rbusy1);
        end
        we = 1'b1; wa = 2'd2; wd = 32'hC0FFEE00; wstrb = 4'hf;
        #1;
        total++;
        if (rbusy1 !== 1'b0 || rd1 !== 32'hC0FFEE00) begin
            bad++;
            $display("FAIL busy_bypass: rbusy1=%b rd1=%h required 0 c0ffee00", rbusy1, rd1);
        end
        tick();
        idle();
        #1;
        total++;
        if (pend_cnt !== 3'd2 || rbusy1 !== 1'b0) begin
            bad++;
            $display("FAIL writeback_clear: pend_cnt=%0d rbusy1=%b required 2 0", pend_cnt, rbusy1);
        end
    endtask

    task automatic test_issue_wins();
        iss_valid = 1'b1; iss_addr = 2'd1;
        we = 1'b1; wa = 2'd1; wd = 32'h5A5A5A5A; wstrb = 4'hf; ra2 = 2'd1;
        #1;
        total++;
        if (rbusy2 !== 1'b1 || rd2 !== 32'h5A5A5A5A) begin
            bad++;
            $display("FAIL same_cycle_busy: rbusy2=%b rd2=%h required 1 5a5a5a5a", rbusy2, rd2);
        end
        tick();
        idle();
        #1;
        total++;
        if (pend_cnt !== 3'd2 || rbusy2 !== 1'b1 || rd2 !== 32'h5A5A5A5A) begin
            bad++;
            $display("FAIL issue_wins: cnt=%0d rbusy2=%b rd2=%h required 2 1 5a5a5a5a", pend_cnt, rbusy2, rd2);
        end
    endtask

    task automatic test_zero_reg();
        z_we = 1'b1; z_wa = 2'd0; z_wd = 32'd100; z_wstrb = 4'hf;
        z_iss_valid = 1'b1; z_iss_addr = 2'd0; z_ra1 = 2'd0; z_ra2 = 2'd0;
        #1;
        total++;
        if (z_rd1 !== 32'h0 || z_rbusy1 !== 1'b0) begin
            bad++;
            $display("FAIL zero_bypass: rd1=%h rbusy1=%b required 0 0", z_rd1, z_rbusy1);
        end
        @(posedge clk);
        #1;
        z_we = 1'b1; z_wa = 2'd1; z_wd = 32'h0BADF00D; z_iss_valid = 1'b0; z_ra2 = 2'd1;
        @(posedge clk);
        #1;
        z_we = 1'b0;
        #1;
        total++;
        if (z_rd1 !== 32'h0 || z_rbusy1 !== 1'b0 || z_pend_cnt !== 3'd0 || z_rd2 !== 32'h0BADF00D) begin
            bad++;
            $display("FAIL zero_reg: rd1=%h rbusy1=%b cnt=%0d rd2=%h required 0 0 0 0badf00d",
                     z_rd1, z_rbusy1, z_pend_cnt, z_rd2);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            ra1 = 2'($urandom_range(0, 3)); ra2 = 2'($urandom_range(0, 3));
            we = 1'($urandom_range(0, 1)); wa = 2'($urandom_range(0, 3));
            wd = $urandom; wstrb = 4'($urandom_range(0, 15));
            iss_valid = ($urandom_range(0, 9) < 4); iss_addr = 2'($urandom_range(0, 3));
            #1;
            total++;
            if (rd1 !== m_read(ra1) || rd2 !== m_read(ra2) ||
                rbusy1 !== m_busy(ra1) || rbusy2 !== m_busy(ra2)) begin
                bad++;
                $display("FAIL random_read: rd1=%h rd2=%h busy=%b%b required %h %h %b%b",
                         rd1, rd2, rbusy1, rbusy2, m_read(ra1), m_read(ra2), m_busy(ra1), m_busy(ra2));
            end
            tick();
            total++;
            if (pend_cnt !== 3'(m_count())) begin
                bad++;
                $display("FAIL random_count: pend_cnt=%0d required %0d", pend_cnt, m_count());
            end
        end
        idle();
    endtask

    task automatic test_midcycle_reset();
        // make sure state is non-zero going in
        we = 1'b1; wa = 2'd3; wd = 32'h87654321; wstrb = 4'hf;
        iss_valid = 1'b1; iss_addr = 2'd1;
        tick();
        idle(); ra1 = 2'd1; ra2 = 2'd3;
        #3;
        rst = 1'b1; we = 1'b1; wa = 2'd1; wd = 32'hDEADBEEF; wstrb = 4'hf;
        model_reset();
        #1;
        total++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0 || rbusy1 !== 1'b0 || rbusy2 !== 1'b0 || pend_cnt !== 3'd0) begin
            bad++;
            $display("FAIL midcycle_reset: rd1=%h rd2=%h busy=%b%b cnt=%0d required all zero",
                     rd1, rd2, rbusy1, rbusy2, pend_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; idle();
        #1;
        total++;
        if (rd1 !== 32'h0 || pend_cnt !== 3'd0) begin
            bad++;
            $display("FAIL write_in_reset: rd1=%h cnt=%0d required 0 0", rd1, pend_cnt);
        end
        we = 1'b1; wa = 2'd1; wd = 32'h12345678; wstrb = 4'hf;
        tick();
        idle();
        #1;
        total++;
        if (rd1 !== 32'h12345678) begin
            bad++;
            $display("FAIL write_after_reset: rd1=%h required 12345678", rd1);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobe_bypass();
        test_scoreboard();
        test_issue_wins();
        test_zero_reg();
        test_midcycle_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
